// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
// Presents one instruction at a time to the execute stage. Handles
// branch/jump redirects, drops an in-flight read that a redirect made stale,
// and latches a sticky fault on a misaligned redirect target.
module instr_fetch #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  fault
);

    // START : one idle cycle after reset before the first request
    // FETCH : read outstanding, waiting for mem_ack
    // HOLD  : instruction presented, waiting for instr_ready
    // DROP  : read outstanding whose data is no longer wanted
    // FAULT : misaligned redirect seen; parked until reset
    typedef enum logic [2:0] {
        START = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        DROP  = 3'd3,
        FAULT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        mem_req_q, mem_req_d;
    logic        fault_q, fault_d;

    logic        redirect_misaligned;
    logic [31:0] drop_pc;

    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        drop_pc    = pc_q;

        unique case (state_q)
            START: begin
                // Any mem_ack here belongs to a read abandoned by reset.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = redirect_misaligned ? FAULT : FETCH;
                end else begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    if (!mem_ack) begin
                        // Read still in flight: its data must be swallowed.
                        state_d = DROP;
                    end else if (redirect_misaligned) begin
                        state_d = FAULT;
                    end else begin
                        // Read completed this cycle; discard and refetch.
                        state_d = FETCH;
                    end
                end else if (mem_ack) begin
                    instr_d    = mem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                // Redirect beats acceptance: the target replaces pc, no +4.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = redirect_misaligned ? FAULT : FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end

            DROP: begin
                // Later redirects keep updating pc; the fault decision waits
                // until the pending read has been consumed.
                drop_pc = redirect_valid ? redirect_pc : pc_q;
                pc_d    = drop_pc;
                if (mem_ack) begin
                    state_d = (drop_pc[1:0] != 2'b00) ? FAULT : FETCH;
                end
            end

            FAULT: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = START;
                valid_d = 1'b0;
            end
        endcase

        // Outputs are registered, decoded from the state being entered.
        mem_req_d = (state_d == FETCH);
        fault_d   = (state_d == FAULT);
    end

    // State, pc and presented-instruction registers with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
            fault_q    <= fault_d;
        end
    end

    // Word address aliases modulo the memory size; instr_pc keeps 32 bits.
    assign mem_addr    = pc_q[ADDR_WIDTH+1:2];
    assign mem_req     = mem_req_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

    // A faulted unit neither requests nor presents anything.
    a_fault_quiet: assert property (@(posedge clk) disable iff (reset)
        fault |-> (!mem_req && !instr_valid));

    // A request and a presented instruction never coexist.
    a_req_excl_valid: assert property (@(posedge clk) disable iff (reset)
        mem_req |-> !instr_valid);

    // A stalled instruction stays put until accepted or redirected.
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (instr_valid && !instr_ready && !redirect_valid)
            |=> ($stable(instr) && $stable(instr_pc)));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic for instr_fetch,
// checked cycle by cycle against a transaction-level reference model.
module tb_instr_fetch;

    localparam int          AW        = 10;
    localparam logic [31:0] RST_PC    = 32'h0;
    localparam int          ROM_WORDS = 1 << AW;

    logic          clk;
    logic          reset;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          fault;

    instr_fetch #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rom [ROM_WORDS];
    int          n_vec = 0;
    int          n_err = 0;

    // Memory responder: one read at a time, latency drawn from a range.
    bit            r_pending;
    int            r_cnt;
    logic [AW-1:0] r_addr;
    int            lat_min = 1;
    int            lat_max = 1;

    // Reference model: what the fetch unit has promised, in abstract terms.
    logic [31:0] m_pc, m_instr, m_instr_pc;
    bit          m_first;   // idle cycle after reset still pending
    bit          m_has;     // an instruction is being presented
    bit          m_stale;   // a read is in flight whose data is unwanted
    bit          m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_instr = 32'h0; m_instr_pc = 32'h0;
        m_first = 1; m_has = 0; m_stale = 0; m_fault = 0;
    endtask

    // Apply one clock edge worth of inputs to the model.
    task automatic model_update(input bit ack, input logic [31:0] rd, input bit rv,
                                input logic [31:0] rpc, input bit rdy);
        if (m_fault) begin
            m_has = 0;
        end else if (m_first) begin
            m_first = 0;
            if (rv) begin m_pc = rpc; m_fault = misaligned(rpc); end
        end else if (m_stale) begin
            if (rv) m_pc = rpc;
            if (ack) begin m_stale = 0; m_fault = misaligned(m_pc); end
        end else if (m_has) begin
            if (rv) begin m_pc = rpc; m_has = 0; m_fault = misaligned(rpc); end
            else if (rdy) begin m_pc = m_pc + 32'd4; m_has = 0; end
        end else begin
            if (rv) begin
                m_pc = rpc;
                if (!ack) m_stale = 1;
                else m_fault = misaligned(rpc);
            end else if (ack) begin
                m_has = 1; m_instr = rd; m_instr_pc = m_pc;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = !m_first && !m_has && !m_stale && !m_fault;
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", 32'(mem_addr), 32'(m_pc[AW+1:2]));
        check("instr_valid", 32'(instr_valid), 32'(m_has));
        check("fault", 32'(fault), 32'(m_fault));
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_instr_pc);
        if (instr_valid) check("rom_word", instr, rom[instr_pc[AW+1:2]]);
    endtask

    // Drive one cycle of inputs, clock it, update the model, compare.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit spur);
        bit          ack;
        logic [31:0] rd;
        ack = 0;
        rd  = $urandom;
        if (r_pending) begin
            r_cnt--;
            if (r_cnt == 0) begin ack = 1; rd = rom[r_addr]; r_pending = 0; end
        end else if (mem_req) begin
            r_pending = 1; r_addr = mem_addr; r_cnt = $urandom_range(lat_max, lat_min);
        end else if (spur) begin
            ack = 1;   // unsolicited ack while no read is outstanding
        end
        mem_ack = ack; mem_rdata = rd;
        redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
        @(posedge clk);
        model_update(ack, rd, rv, rpc, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_mem_addr", 32'(mem_addr), 32'(RST_PC[AW+1:2]));
        mem_ack = 0; mem_rdata = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
        r_pending = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            step(0, 32'h0, 0, 0);
            n++;
        end
        check({tag, "_timeout"}, 32'(instr_valid), 1);
    endtask

    task automatic test_basic();
        logic [31:0] seen_pc [$];
        logic [31:0] seen_ins [$];
        logic [31:0] exp_pc  [3];
        logic [31:0] exp_ins [3];
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        exp_ins = '{32'h07800293, 32'h0C800293, 32'h7D000293};
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 40 && seen_pc.size() < 3; i++) begin
            step(0, 32'h0, 1, 0);
            if (instr_valid) begin
                seen_pc.push_back(instr_pc);
                seen_ins.push_back(instr);
            end
        end
        check("basic_count", 32'(seen_pc.size()), 3);
        for (int k = 0; k < seen_pc.size() && k < 3; k++) begin
            check("basic_pc", seen_pc[k], exp_pc[k]);
            check("basic_instr", seen_ins[k], exp_ins[k]);
        end
    endtask

    task automatic test_stall();
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_valid("stall", 20);
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 0, 0);
            check("stall_instr", instr, rom[0]);
            check("stall_pc", instr_pc, RST_PC);
            check("stall_req", 32'(mem_req), 0);
        end
        step(0, 32'h0, 1, 0);
        check("stall_release_req", 32'(mem_req), 1);
        check("stall_release_addr", 32'(mem_addr), 1);
    endtask

    task automatic test_drop();
        int n;
        lat_min = 3; lat_max = 3;
        do_reset();
        step(0, 32'h0, 0, 0);
        check("drop_first_req", 32'(mem_req), 1);
        step(0, 32'h0, 0, 0);
        step(1, 32'h20, 0, 0);
        check("drop_req_low", 32'(mem_req), 0);
        n = 0;
        while (!mem_req && n < 10) begin step(0, 32'h0, 0, 0); n++; end
        check("drop_refetch", 32'(mem_req), 1);
        check("drop_addr", 32'(mem_addr), 8);
        wait_valid("drop", 20);
        check("drop_instr_pc", instr_pc, 32'h20);
        check("drop_instr", instr, rom[8]);
    endtask

    task automatic test_redirect_accept();
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_valid("racc_a", 20);
        step(0, 32'h0, 1, 0);
        wait_valid("racc_b", 20);
        check("racc_pc4", instr_pc, 32'h4);
        step(1, 32'h40, 1, 0);
        check("racc_valid_drop", 32'(instr_valid), 0);
        wait_valid("racc_c", 20);
        check("racc_target_pc", instr_pc, 32'h40);
        check("racc_target_instr", instr, rom[16]);
    endtask

    task automatic test_fault();
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_valid("fault", 20);
        step(1, 32'h22, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(i[0], 32'h80, 1'($urandom_range(0, 1)), 1);
            check("fault_flag", 32'(fault), 1);
            check("fault_req", 32'(mem_req), 0);
            check("fault_valid", 32'(instr_valid), 0);
        end
        do_reset();
        wait_valid("fault_restart", 20);
        check("fault_restart_pc", instr_pc, RST_PC);
        check("fault_cleared", 32'(fault), 0);
    endtask

    task automatic test_reset_midread();
        lat_min = 1; lat_max = 1;
        do_reset();
        step(1, 32'h100, 0, 0);
        wait_valid("midrd_a", 20);
        check("midrd_pc", instr_pc, 32'h100);
        lat_min = 3; lat_max = 3;
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 0);
        check("midrd_inflight", 32'(mem_req), 1);
        do_reset();
        step(0, 32'h0, 0, 1);
        check("midrd_stale_ignored", 32'(instr_valid), 0);
        wait_valid("midrd_b", 20);
        check("midrd_first_pc", instr_pc, RST_PC);
        check("midrd_first_instr", instr, rom[0]);
    endtask

    task automatic test_random(input int cycles);
        bit          rv, rdy, spur;
        logic [31:0] rpc;
        int          sel, fault_age;
        lat_min = 1; lat_max = 4;
        fault_age = 0;
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            rv  = ($urandom_range(0, 99) < 8);
            sel = $urandom_range(0, 19);
            rpc = $urandom;
            if (sel == 0)      rpc[1:0] = 2'b10;
            else if (sel == 1) rpc = 32'hFFFF_FFF8;
            else if (sel < 6)  rpc = rpc & 32'hFFFF_FFFC;
            else               rpc = 32'($urandom_range(0, 255)) << 2;
            rdy  = ($urandom_range(0, 9) < 6);
            spur = ($urandom_range(0, 9) == 0);
            step(rv, rpc, rdy, spur);
            if (m_fault) fault_age++;
            if (fault_age > 12 || $urandom_range(0, 499) == 0) begin
                do_reset();
                fault_age = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        mem_ack = 0; mem_rdata = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
        r_pending = 0; r_cnt = 0; r_addr = '0;
        for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
        rom[0] = 32'h07800293;   // addi x5, x0, 120
        rom[1] = 32'h0C800293;   // addi x5, x0, 200
        rom[2] = 32'h7D000293;   // addi x5, x0, 2000
        model_reset();
        #2;
        test_basic();
        test_stall();
        test_drop();
        test_redirect_accept();
        test_fault();
        test_reset_midread();
        test_random(4000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of program memory.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, byte address fetched first after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  read request to program memory.
REQ-006 SHALL have port mem_addr  output  ADDR_WIDTH  word address, equal to pc[ADDR_WIDTH+1:2].
REQ-007 SHALL have port mem_ack  input  1  read data valid, arriving one or more cycles after mem_req.
REQ-008 SHALL have port mem_rdata  input  32  instruction word, sampled when mem_ack=1.
REQ-009 SHALL have port instr  output  32  held instruction for the execute FSM.
REQ-010 SHALL have port instr_pc  output  32  byte address of instr.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-012 SHALL have port instr_ready  input  1  execute FSM accepts instr this cycle.
REQ-013 SHALL have port redirect_valid  input  1  branch/jump taken.
REQ-014 SHALL have port redirect_pc  input  32  target byte address.
REQ-015 SHALL have port fault  output  1  sticky misaligned-redirect flag.

Function
REQ-016 SHALL implement FSM states START, FETCH, HOLD, DROP, FAULT.
REQ-017 SHALL hold one outstanding memory read at most; mem_req=1 only in FETCH.
REQ-018 START: one cycle after reset deassertion, mem_req=0, then -> FETCH.
REQ-019 FETCH: mem_req=1, mem_addr=pc word; on mem_ack load instr=mem_rdata, instr_pc=pc, instr_valid=1, -> HOLD.
REQ-020 HOLD: instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-021 HOLD with instr_ready=1: instr_valid=0 next cycle, pc<=pc+4 (mod 2^32), -> FETCH; minimum accept-to-next-request latency 1 cycle.
REQ-022 Redirect has priority over all other events in START, FETCH and HOLD: pc<=redirect_pc, instr_valid<=0.
REQ-023 Redirect in HOLD or START (or in FETCH with mem_ack same cycle) -> FETCH; the returned word SHALL be discarded.
REQ-024 Redirect in FETCH without mem_ack -> DROP; DROP: mem_req=0, wait for mem_ack, discard data, -> FETCH; redirect in DROP updates pc, stays DROP.
REQ-025 Redirect with redirect_pc[1:0]!=0 -> FAULT (from DROP, after pending ack is consumed): fault=1, mem_req=0, instr_valid=0 until reset.
REQ-026 Redirect and instr_ready in the same HOLD cycle: redirect wins, pc=redirect_pc, no +4.
REQ-027 mem_ack outside FETCH/DROP SHALL be ignored.
REQ-028 pc wrap past ADDR_WIDTH word range SHALL alias mem_addr modulo 2^ADDR_WIDTH; instr_pc keeps full 32 bits.

Reset
REQ-029 Reset assertion SHALL immediately (asynchronously) force state START, pc=RESET_PC, instr=32'h0, instr_pc=32'h0, instr_valid=0, mem_req=0, fault=0.
REQ-030 Reset mid-read SHALL abandon the read; a later stale mem_ack in START SHALL be ignored.

Verification
REQ-031 Reset, ROM words 0..2 = addi x5,x0,120 / 200 / 2000, ack latency 1, instr_ready=1 always -> instr_valid pulses with instr_pc 0,4,8 in order, instrs match ROM exactly.
REQ-032 instr_ready held 0 for 5 cycles in HOLD -> instr and instr_pc unchanged, mem_req=0 throughout; release -> next mem_addr=1.
REQ-033 Ack latency 3, redirect_pc=32'h20 one cycle after request -> DROP, stale word discarded, next mem_addr=8, instr_pc=32'h20.
REQ-034 Redirect and instr_ready same cycle in HOLD at pc 4 with target 32'h40 -> next instr_pc=32'h40, word 1 never re-presented.
REQ-035 redirect_pc=32'h22 -> fault=1, mem_req=0, instr_valid=0 persist 10 cycles; reset clears fault, fetch restarts at RESET_PC.
REQ-036 Reset asserted between mem_req and mem_ack -> outputs at reset values without clock edge; stale ack ignored; first valid instr_pc=RESET_PC.
